// File: rtl/resp_chk_pkg.sv
// Shared constants and age helpers for the response-window checker.
// Pure definitions: no latency, no backpressure.
package resp_chk_pkg;

  localparam int unsigned DEF_MAX_LAT = 4;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  // Ages run 0..max_lat+1; the extra value is the saturated "overdue" state.
  function automatic int unsigned age_width(input int unsigned max_lat);
    return $clog2(max_lat + 2);
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/age_fifo.sv
// Shift queue of entry ages, oldest at index 0; every surviving entry ages by one per edge.
// Latency: push/pop visible after the edge. No backpressure: caller must not push when full without a pop.
module age_fifo import resp_chk_pkg::*; #(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned MAX_AGE = DEF_MAX_LAT + 1,
  parameter int unsigned AW      = age_width(DEF_MAX_LAT)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  output logic [AW-1:0]              o_head_age,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH*AW-1:0] r_ages;
  logic [DEPTH*AW-1:0] w_shift;
  logic [DEPTH*AW-1:0] w_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_base;

  // Survivors shift down on pop and age; a pushed entry lands just above them at age 0.
  always_comb begin
    w_shift = i_pop ? (r_ages >> AW) : r_ages;
    w_base  = r_cnt - CW'(i_pop);
    w_nxt   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) < w_base) begin
        w_nxt[i*AW +: AW] = AW'(sat_inc(32'(w_shift[i*AW +: AW]), MAX_AGE));
      end else if (i_push && (CW'(i) == w_base)) begin
        w_nxt[i*AW +: AW] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ages <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_ages <= '0;
      r_cnt  <= '0;
    end else begin
      r_ages <= w_nxt;
      r_cnt  <= w_base + CW'(i_push);
    end
  end

  assign o_head_age = r_ages[AW-1:0];
  assign o_count    = r_cnt;
  assign o_full     = (r_cnt == CW'(DEPTH));
  assign o_empty    = (r_cnt == '0);

endmodule

// File: rtl/resp_window_checker.sv
// Matches each consequent to the oldest outstanding antecedent; counts hits/misses, flags anomalies.
// Latency: all outputs registered, one edge. No backpressure: excess antecedents are dropped and flagged.
module resp_window_checker import resp_chk_pkg::*; #(
  parameter int unsigned MAX_LAT = DEF_MAX_LAT,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       antecedent,
  input  logic                       consequent,
  input  logic                       clear,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       timeout,
  output logic                       overflow,
  output logic                       spurious
);

  localparam int unsigned AW = age_width(MAX_LAT);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [AW-1:0]    w_head_age;
  logic [OW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_head_due;
  logic             w_hit;
  logic             w_spur;
  logic             w_expire;
  logic             w_pop;
  logic             w_ant_pend;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;
  logic             r_timeout;
  logic             r_overflow;
  logic             r_spurious;

  // Saturated ages stay >= MAX_LAT, so an entry that missed its pop slot expires next cycle.
  always_comb begin
    w_head_due = !w_empty && (w_head_age >= AW'(MAX_LAT));
    w_hit      = consequent && (!w_empty || antecedent);
    w_spur     = consequent && w_empty && !antecedent;
    w_expire   = !consequent && w_head_due;
    w_pop      = consequent ? !w_empty : w_head_due;
    w_ant_pend = antecedent && !(consequent && w_empty);
    w_push     = w_ant_pend && (!w_full || w_pop);
    w_drop     = w_ant_pend && w_full && !w_pop;
  end

  age_fifo #(
    .DEPTH   (DEPTH),
    .MAX_AGE (MAX_LAT + 1),
    .AW      (AW)
  ) u_age_fifo (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_clr      (clear),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .o_head_age (w_head_age),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_spurious   <= 1'b0;
    end else if (clear) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      if (w_hit && !(&r_hit_count)) r_hit_count <= r_hit_count + CNT_W'(1);
      if (w_expire && !(&r_miss_count)) r_miss_count <= r_miss_count + CNT_W'(1);
      r_timeout  <= w_expire;
      r_overflow <= r_overflow | w_drop;
      r_spurious <= r_spurious | w_spur;
    end
  end

  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign outstanding = w_count;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign spurious    = r_spurious;

  a_timeout_pairs: assert property (@(posedge clk) disable iff (!reset_n)
    timeout |=> (!timeout || (miss_count != $past(miss_count)) || (&miss_count)));

  a_outstanding_max: assert property (@(posedge clk) disable iff (!reset_n)
    outstanding <= OW'(DEPTH));

  a_hit_monotonic: assert property (@(posedge clk) disable iff (!reset_n)
    !clear |=> (hit_count >= $past(hit_count)));

endmodule

// File: tb/tb_resp_window_checker.sv
// Bench for resp_window_checker: timestamp-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_resp_window_checker;

  localparam int MAX_LAT = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             antecedent;
  logic             consequent;
  logic             clear;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [2:0]       outstanding;
  logic             timeout;
  logic             overflow;
  logic             spurious;

  resp_window_checker #(
    .MAX_LAT (MAX_LAT),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .antecedent  (antecedent),
    .consequent  (consequent),
    .clear       (clear),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .outstanding (outstanding),
    .timeout     (timeout),
    .overflow    (overflow),
    .spurious    (spurious)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Reference model: each outstanding antecedent is remembered by the edge it arrived on.
  int q[$];
  int m_edge = 0;
  int m_hit  = 0;
  int m_miss = 0;
  bit m_to   = 0;
  bit m_ovf  = 0;
  bit m_spur = 0;
  bit m_consumed;
  bit m_expired;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_hit = 0; m_miss = 0; m_to = 0; m_ovf = 0; m_spur = 0;
    end else begin
      m_edge++;
      m_consumed = 0;
      m_expired  = 0;
      if (clear) begin
        q.delete();
        m_hit = 0; m_miss = 0; m_ovf = 0; m_spur = 0;
      end else begin
        if (consequent) begin
          if (q.size() > 0) begin
            void'(q.pop_front());
            if (m_hit < CNT_MAX) m_hit++;
          end else if (antecedent) begin
            if (m_hit < CNT_MAX) m_hit++;
            m_consumed = 1;
          end else begin
            m_spur = 1;
          end
        end else if (q.size() > 0 && (m_edge - q[0]) > MAX_LAT) begin
          void'(q.pop_front());
          m_expired = 1;
          if (m_miss < CNT_MAX) m_miss++;
        end
        if (antecedent && !m_consumed) begin
          if (q.size() < DEPTH) q.push_back(m_edge);
          else m_ovf = 1;
        end
      end
      m_to = m_expired;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_hit_count",   int'(hit_count),   m_hit);
      chk("model_miss_count",  int'(miss_count),  m_miss);
      chk("model_outstanding", int'(outstanding), q.size());
      chk("model_timeout",     int'(timeout),     int'(m_to));
      chk("model_overflow",    int'(overflow),    int'(m_ovf));
      chk("model_spurious",    int'(spurious),    int'(m_spur));
    end
  end

  task automatic cyc(input bit a, input bit c, input bit cl);
    antecedent = a;
    consequent = c;
    clear      = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pa;
    int pc;
    clk = 0; reset_n = 1; antecedent = 0; consequent = 0; clear = 0;
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hit", int'(hit_count), 0);
    chk("reset_outstanding", int'(outstanding), 0);
    chk("reset_flags", int'({timeout, overflow, spurious}), 0);
    reset_n = 1;
    cmp_en  = 1;

    // Single hit one cycle after the antecedent.
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    chk("t1_outstanding_after_push", int'(outstanding), 1);
    cyc(0, 1, 0);
    chk("t1_hit", int'(hit_count), 1);
    chk("t1_outstanding", int'(outstanding), 0);
    chk("t1_timeout", int'(timeout), 0);

    // Expiry with no consequent.
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    for (int k = 1; k <= MAX_LAT; k++) begin
      cyc(0, 0, 0);
      chk("t2_no_early_timeout", int'(timeout), 0);
    end
    cyc(0, 0, 0);
    chk("t2_timeout", int'(timeout), 1);
    chk("t2_miss", int'(miss_count), 1);
    chk("t2_outstanding", int'(outstanding), 0);
    cyc(0, 0, 0);
    chk("t2_timeout_single", int'(timeout), 0);

    // Consequent at distance MAX_LAT is a hit.
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (MAX_LAT - 1) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t3_hit", int'(hit_count), 1);
    repeat (3) cyc(0, 0, 0);
    chk("t3_no_miss", int'(miss_count), 0);

    // Five back-to-back antecedents into a four-deep queue.
    cyc(0, 0, 1);
    repeat (5) cyc(1, 0, 0);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_outstanding", int'(outstanding), 4);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk("t4_timeout_train", int'(timeout), 1);
    end
    cyc(0, 0, 0);
    chk("t4_timeout_end", int'(timeout), 0);
    chk("t4_miss", int'(miss_count), 4);

    // Spurious consequent, then same-cycle hit on an empty queue.
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("t5_spurious", int'(spurious), 1);
    cyc(1, 1, 0);
    chk("t5_same_cycle_hit", int'(hit_count), 1);
    chk("t5_no_push", int'(outstanding), 0);

    // Hit counter saturation, then clear with all other inputs high.
    cyc(0, 0, 1);
    repeat (CNT_MAX + 5) cyc(1, 1, 0);
    chk("t6_hit_saturated", int'(hit_count), CNT_MAX);
    cyc(1, 1, 1);
    chk("t6_clear_hit", int'(hit_count), 0);
    chk("t6_clear_outstanding", int'(outstanding), 0);

    // Asynchronous reset with entries queued.
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t7_outstanding_before", int'(outstanding), 2);
    antecedent = 0;
    #2 reset_n = 0;
    #1 chk("t7_async_reset", int'(outstanding), 0);
    @(posedge clk);
    #1 reset_n = 1;
    cyc(1, 0, 0);
    chk("t7_first_edge_after_reset", int'(outstanding), 1);

    // Randomized traffic across several density mixes.
    for (int blk = 0; blk < 6; blk++) begin
      pa = 20 + 15 * blk;
      pc = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 35 : 60);
      for (int n = 0; n < 500; n++) begin
        cyc($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pc,
            $urandom_range(0, 127) == 0);
      end
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
